// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32 decode-then-queue FIFO; optional illegal flag under DECODE_QUEUE_ILLEGAL_EN
package decode_queue_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    alu_nop, alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
    alu_xor, alu_srl, alu_sra, alu_or, alu_and
  } alu_fn_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
    word_t      imm;
    alu_fn_t    alu_fn;
    logic       use_pc;
    logic       use_imm;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_mret;
    logic       has_rd;
  } instruction_t;

  localparam logic [6:0] op_lui      = 7'b0110111;
  localparam logic [6:0] op_auipc    = 7'b0010111;
  localparam logic [6:0] op_jal      = 7'b1101111;
  localparam logic [6:0] op_jalr     = 7'b1100111;
  localparam logic [6:0] op_branch   = 7'b1100011;
  localparam logic [6:0] op_load     = 7'b0000011;
  localparam logic [6:0] op_store    = 7'b0100011;
  localparam logic [6:0] op_imm      = 7'b0010011;
  localparam logic [6:0] op_op       = 7'b0110011;
  localparam logic [6:0] op_misc_mem = 7'b0001111;
  localparam logic [6:0] op_system   = 7'b1110011;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  word_t                      in_data,
  input  word_t                      in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output instruction_t               out_instr,
  output word_t                      out_pc,
`ifdef DECODE_QUEUE_ILLEGAL_EN
  output logic                       out_illegal,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] full_count = CW'(DEPTH);

  logic [PW-1:0] wptr, rptr;
  logic          push, pop;
  logic [6:0]    opc;
  logic [2:0]    f3;
  logic [6:0]    f7;
  instruction_t  dec;

  instruction_t  instr_mem [DEPTH];
  word_t         pc_mem    [DEPTH];

  assign opc = in_data[6:0];
  assign f3  = in_data[14:12];
  assign f7  = in_data[31:25];

  always_comb begin
    dec        = '0;
    dec.funct7 = f7;
    dec.rs2    = in_data[24:20];
    dec.rs1    = in_data[19:15];
    dec.funct3 = f3;
    dec.rd     = in_data[11:7];
    dec.opcode = opc;
    case (opc)
      op_op:            dec.imm = '0;
      op_store:         dec.imm = {{20{in_data[31]}}, in_data[31:25], in_data[11:7]};
      op_branch:        dec.imm = {{19{in_data[31]}}, in_data[31], in_data[7],
                                   in_data[30:25], in_data[11:8], 1'b0};
      op_lui, op_auipc: dec.imm = {in_data[31:12], 12'h000};
      op_jal:           dec.imm = {{11{in_data[31]}}, in_data[31], in_data[19:12],
                                   in_data[20], in_data[30:21], 1'b0};
      default:          dec.imm = {{20{in_data[31]}}, in_data[31:20]};
    endcase

    // For OP_IMM the funct7 slot is imm[11:5], which is how SRAI is told apart
    dec.alu_fn = alu_add;
    if (opc == op_lui) begin
      dec.alu_fn = alu_nop;
    end else if (opc == op_op || opc == op_imm) begin
      case (f3)
        3'b000:  dec.alu_fn = (opc == op_op && f7 == 7'h20) ? alu_sub : alu_add;
        3'b001:  dec.alu_fn = alu_sll;
        3'b010:  dec.alu_fn = alu_slt;
        3'b011:  dec.alu_fn = alu_sltu;
        3'b100:  dec.alu_fn = alu_xor;
        3'b101:  dec.alu_fn = (f7 == 7'h20) ? alu_sra : alu_srl;
        3'b110:  dec.alu_fn = alu_or;
        default: dec.alu_fn = alu_and;
      endcase
    end

    dec.use_pc    = (opc == op_auipc) || (opc == op_jal) || (opc == op_branch);
    dec.use_imm   = (opc != op_op);
    dec.is_load   = (opc == op_load);
    dec.is_store  = (opc == op_store);
    dec.is_branch = (opc == op_branch);
    dec.is_jump   = (opc == op_jal) || (opc == op_jalr);
    dec.is_mret   = (opc == op_system) && (f3 == 3'b000) && (in_data[31:20] == 12'h302);
    dec.has_rd    = (opc != op_branch) && (opc != op_store) && (in_data[11:7] != 5'd0);
  end

  assign in_ready  = (count < full_count);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count gates visibility of every slot
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr] <= dec;
      pc_mem[wptr]    <= in_pc;
    end
  end

  assign out_instr = instr_mem[rptr];
  assign out_pc    = pc_mem[rptr];

`ifdef DECODE_QUEUE_ILLEGAL_EN
  logic dec_illegal;
  logic ill_mem [DEPTH];

  assign dec_illegal = (in_data[1:0] != 2'b11) ||
                       !(opc inside {op_lui, op_auipc, op_jal, op_jalr, op_branch, op_load,
                                     op_store, op_imm, op_op, op_misc_mem, op_system});

  always_ff @(posedge clk) begin
    if (push) ill_mem[wptr] <= dec_illegal;
  end

  assign out_illegal = out_valid && ill_mem[rptr];
`endif
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 2;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          in_valid, in_ready, flush, out_valid, out_ready;
  word_t                         in_data, in_pc, out_pc;
  instruction_t                  out_instr;
  logic [$clog2(DEPTH+1)-1:0]    count;
`ifdef DECODE_QUEUE_ILLEGAL_EN
  logic                          out_illegal;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct { word_t w; word_t pc; } ent_t;
  ent_t mq[$];
  bit   m_push, m_pop;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
`ifdef DECODE_QUEUE_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instruction_t ref_decode(input word_t w);
    instruction_t        r;
    logic signed [31:0]  s;
    logic [6:0]          opc;
    alu_fn_t             f3map [8];
    f3map = '{alu_add, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_or, alu_and};
    s   = w;
    opc = w[6:0];
    r   = '0;
    r.funct7 = w[31:25]; r.rs2 = w[24:20]; r.rs1 = w[19:15];
    r.funct3 = w[14:12]; r.rd  = w[11:7];  r.opcode = opc;
    if (opc == op_op)                            r.imm = 32'h0;
    else if (opc == op_store)                    r.imm = word_t'((s >>> 25) <<< 5) | {27'h0, w[11:7]};
    else if (opc == op_branch)                   r.imm = word_t'((s >>> 31) <<< 12) |
                                                         {20'h0, w[7], w[30:25], w[11:8], 1'b0};
    else if (opc == op_lui || opc == op_auipc)   r.imm = w & 32'hFFFF_F000;
    else if (opc == op_jal)                      r.imm = word_t'((s >>> 31) <<< 20) |
                                                         {12'h0, w[19:12], w[20], w[30:21], 1'b0};
    else                                         r.imm = word_t'(s >>> 20);
    if (opc == op_lui) r.alu_fn = alu_nop;
    else if (opc == op_op || opc == op_imm) begin
      r.alu_fn = f3map[w[14:12]];
      if (w[14:12] == 3'd5 && w[31:25] == 7'h20) r.alu_fn = alu_sra;
      if (w[14:12] == 3'd0 && w[31:25] == 7'h20 && opc == op_op) r.alu_fn = alu_sub;
    end else r.alu_fn = alu_add;
    r.use_pc    = opc inside {op_auipc, op_jal, op_branch};
    r.use_imm   = opc != op_op;
    r.is_load   = opc == op_load;
    r.is_store  = opc == op_store;
    r.is_branch = opc == op_branch;
    r.is_jump   = opc inside {op_jal, op_jalr};
    r.is_mret   = w == 32'h3020_0073 || (opc == op_system && w[14:12] == 0 && w[31:20] == 12'h302);
    r.has_rd    = !(opc inside {op_branch, op_store}) && w[11:7] != 0;
    return r;
  endfunction

  function automatic logic ref_illegal(input word_t w);
    return !(w[6:0] inside {op_lui, op_auipc, op_jal, op_jalr, op_branch, op_load,
                            op_store, op_imm, op_op, op_misc_mem, op_system});
  endfunction

  // Reference queue: plain push/pop on a SystemVerilog queue
  always @(posedge clk or posedge reset) begin
    if (reset || flush) mq.delete();
    else begin
      m_pop  = mq.size() > 0 && out_ready;
      m_push = in_valid && mq.size() < DEPTH;
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back('{in_data, in_pc});
    end
  end

  always @(negedge clk) begin
    chk("count", count, mq.size());
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, mq.size() < DEPTH);
    if (mq.size() != 0) begin
      chk("out_instr", out_instr, ref_decode(mq[0].w));
      chk("out_pc", out_pc, mq[0].pc);
`ifdef DECODE_QUEUE_ILLEGAL_EN
      chk("out_illegal", out_illegal, ref_illegal(mq[0].w));
`endif
    end
  end

  task automatic cyc(input logic v, input word_t d, input word_t p, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  word_t stream [10] = '{32'h123450B7, 32'h00001117, 32'h008000EF, 32'h000080E7, 32'h00412183,
                         32'hFE312E23, 32'h4020D193, 32'h0020D1B3, 32'h0020A1B3, 32'h0000000F};

  initial begin
    reset = 1'b1; in_valid = 0; in_data = 0; in_pc = 0; out_ready = 0; flush = 0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef DECODE_QUEUE_ILLEGAL_EN
    chk("rst_out_illegal", out_illegal, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // addi x1,x0,5
    cyc(1, 32'h00500093, 32'h100, 0, 0);
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_instr.rd, 1);
    chk("addi_rs1", out_instr.rs1, 0);
    chk("addi_imm", out_instr.imm, 5);
    chk("addi_alu", out_instr.alu_fn, alu_add);
    chk("addi_use_imm", out_instr.use_imm, 1);
    chk("addi_has_rd", out_instr.has_rd, 1);
    chk("addi_pc", out_pc, 32'h100);
    cyc(0, 0, 0, 1, 0);
    chk("drain_count", count, 0);

    // fill, hold third word, then release with out_ready
    cyc(1, 32'h00100113, 32'h200, 0, 0);
    cyc(1, 32'h00200193, 32'h204, 0, 0);
    chk("full_count", count, 2);
    chk("full_in_ready", in_ready, 0);
    cyc(1, 32'h00300213, 32'h208, 0, 0);
    chk("held_count", count, 2);
    chk("held_head_pc", out_pc, 32'h200);
    cyc(1, 32'h00300213, 32'h208, 1, 0);
    chk("fullpop_count", count, 1);
    chk("fullpop_head_pc", out_pc, 32'h204);
    cyc(1, 32'h00300213, 32'h208, 1, 0);
    chk("repush_count", count, 1);
    chk("repush_head_pc", out_pc, 32'h208);
    cyc(0, 0, 0, 1, 0);

    // sub / beq -4 / mret / lui
    cyc(1, 32'h40208033, 32'h300, 0, 0);
    chk("sub_alu", out_instr.alu_fn, alu_sub);
    cyc(1, 32'hFE000EE3, 32'h304, 1, 0);
    chk("beq_imm", out_instr.imm, 32'hFFFF_FFFC);
    chk("beq_use_pc", out_instr.use_pc, 1);
    chk("beq_has_rd", out_instr.has_rd, 0);
    cyc(1, 32'h30200073, 32'h308, 1, 0);
    chk("mret_flag", out_instr.is_mret, 1);
    cyc(1, 32'h123450B7, 32'h30C, 1, 0);
    chk("lui_alu", out_instr.alu_fn, alu_nop);
    chk("lui_imm", out_instr.imm, 32'h1234_5000);
    cyc(0, 0, 0, 1, 0);

    // flush overrides a simultaneous push
    cyc(1, 32'h00100113, 32'h400, 0, 0);
    cyc(1, 32'h00200193, 32'h404, 0, 0);
    cyc(1, 32'h00300213, 32'h408, 0, 1);
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    cyc(0, 0, 0, 1, 0);
    chk("flush_discard", out_valid, 0);

    // mixed stream exercising pointer wrap
    for (int i = 0; i < 16; i++)
      cyc((i % 3) != 2, stream[i % 10], 32'h500 + 4 * i, (i % 4) != 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

    // asynchronous reset mid-operation
    cyc(1, 32'h00100113, 32'h600, 0, 0);
    cyc(1, 32'h00200193, 32'h604, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(0, 0, 0, 1, 0);
    chk("postrst_valid", out_valid, 0);

`ifdef DECODE_QUEUE_ILLEGAL_EN
    cyc(1, 32'h00000000, 32'h700, 0, 0);
    chk("ill_zero", out_illegal, 1);
    cyc(1, 32'h0000007F, 32'h704, 1, 0);
    chk("ill_7f", out_illegal, 1);
    cyc(1, 32'h00000013, 32'h708, 1, 0);
    chk("ill_nop", out_illegal, 0);
    cyc(0, 0, 0, 1, 0);
`endif

    cyc(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
